if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue.sv | 89 ++++++++
 tb/tb_if_id_queue.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular FIFO between fetch and decode with flush, stall and bubble output.
// Optional macro IF_ID_QUEUE_STATS_EN adds saturating stall/flush cycle counters.
module if_id_queue #(
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        PC_W      = 32,
  parameter int unsigned        DEPTH     = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     stall,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [INSTR_W-1:0]       instr_in,
  input  logic [PC_W-1:0]          pc_in,
  output logic                     out_valid,
  output logic [INSTR_W-1:0]       instr_out,
  output logic [PC_W-1:0]          pc_out,
  output logic [$clog2(DEPTH):0]   count
`ifdef IF_ID_QUEUE_STATS_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              flush_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PC_W-1:0]    last_pc;
  logic               do_push;
  logic               do_pop;

  // Head is read straight from storage; an empty queue presents a bubble.
  assign push_ready = (count != CNT_W'(DEPTH));
  assign out_valid  = (count != '0);
  assign instr_out  = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;
  assign pc_out     = out_valid ? pc_mem[rd_ptr] : last_pc;
  assign do_push    = push_valid && push_ready && !flush;
  assign do_pop     = out_valid && !stall && !flush;

  // Storage is not reset; only written on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      instr_mem[wr_ptr] <= instr_in;
      pc_mem[wr_ptr]    <= pc_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last_pc <= '0;
    end else begin
      // last_pc tracks whichever head leaves the queue, by pop or by flush.
      if (flush ? out_valid : do_pop) last_pc <= pc_mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (do_push && !do_pop)      count <= count + CNT_W'(1);
        else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
    end
  end

`ifdef IF_ID_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && out_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF)              flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a reference queue model predicts every output each cycle.
module tb_if_id_queue;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        stall;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        out_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [2:0]  count;
`ifdef IF_ID_QUEUE_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  int          m_stall;
  int          m_flush;
`endif

  entry_t      sb[$];
  logic [31:0] m_last_pc;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  if_id_queue #(.INSTR_W(INSTR_W), .PC_W(PC_W), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .push_valid(push_valid), .push_ready(push_ready),
    .instr_in(instr_in), .pc_in(pc_in),
    .out_valid(out_valid), .instr_out(instr_out), .pc_out(pc_out), .count(count)
`ifdef IF_ID_QUEUE_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every visible output against the model's current head.
  task automatic check_outputs(input string tag);
    check({tag, ".count"}, 64'(count), 64'(sb.size()));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(sb.size() != 0));
    check({tag, ".push_ready"}, 64'(push_ready), 64'(sb.size() < DEPTH));
    if (sb.size() != 0) begin
      check({tag, ".instr_out"}, 64'(instr_out), 64'(sb[0].instr));
      check({tag, ".pc_out"}, 64'(pc_out), 64'(sb[0].pc));
    end else begin
      check({tag, ".instr_out"}, 64'(instr_out), 64'(NOP));
      check({tag, ".pc_out"}, 64'(pc_out), 64'(m_last_pc));
    end
`ifdef IF_ID_QUEUE_STATS_EN
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    check({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`endif
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
  task automatic step(input string tag, input logic f, input logic s, input logic pv,
                      input logic [31:0] ins, input logic [31:0] p);
    logic   acc_push;
    logic   acc_pop;
    entry_t e;
    flush = f; stall = s; push_valid = pv; instr_in = ins; pc_in = p;
    acc_push = pv && (sb.size() < DEPTH) && !f;
    acc_pop  = (sb.size() != 0) && !s && !f;
`ifdef IF_ID_QUEUE_STATS_EN
    if (s && sb.size() != 0) m_stall++;
    if (f) m_flush++;
`endif
    @(posedge clk);
    if (f) begin
      if (sb.size() != 0) m_last_pc = sb[0].pc;
      sb.delete();
    end else begin
      if (acc_pop) begin
        e = sb.pop_front();
        m_last_pc = e.pc;
      end
      if (acc_push) sb.push_back('{instr: ins, pc: p});
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic model_reset();
    sb.delete();
    m_last_pc = '0;
`ifdef IF_ID_QUEUE_STATS_EN
    m_stall = 0;
    m_flush = 0;
`endif
  endtask

  initial begin
    rst = 1'b1; flush = 0; stall = 0; push_valid = 0; instr_in = '0; pc_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    // Single push becomes visible one cycle later.
    step("push1", 0, 1, 1, 32'h8C22_0004, 32'h40);
    check("push1.instr_exact", 64'(instr_out), 64'h8C22_0004);
    check("push1.pc_exact", 64'(pc_out), 64'h40);

    // Fill under stall, then a fifth push must be dropped.
    for (int i = 1; i < 4; i++) step("fill", 0, 1, 1, 32'h1000_0000 + 32'(i), 32'h40 + 32'(4 * i));
    step("full_drop", 0, 1, 1, 32'hDEAD_BEEF, 32'hBAD0);
    check("full_drop.count", 64'(count), 64'd4);
    check("full_drop.head_pc", 64'(pc_out), 64'h40);

    // Streaming with push_valid held: pointers wrap twice.
    for (int i = 0; i < 8; i++) step("stream", 0, 0, 1, 32'h2000_0000 + 32'(i), 32'h100 + 32'(4 * i));
    step("refill", 0, 1, 1, 32'h2000_0008, 32'h120);
    check("refill.count", 64'(count), 64'd4);

    // Flush to empty, build count=3 with head 0x48, then flush alongside a push.
    step("flush0", 1, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) step("build3", 0, 1, 1, 32'h3000_0000 + 32'(i), 32'h48 + 32'(4 * i));
    check("build3.count", 64'(count), 64'd3);
    step("flush_push", 1, 0, 1, 32'h4444_4444, 32'h999);
    check("flush_push.pc_out", 64'(pc_out), 64'h48);
    check("flush_push.count", 64'(count), 64'd0);

    // Stall on an empty queue has no effect.
    step("empty_stall", 0, 1, 0, '0, '0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), $urandom, $urandom);

    // Asynchronous reset asserted mid-cycle with two entries.
    step("pre_rst_f", 1, 0, 0, '0, '0);
    step("pre_rst_a", 0, 1, 1, 32'h5000_0000, 32'h200);
    step("pre_rst_b", 0, 1, 1, 32'h5000_0001, 32'h204);
    flush = 0; stall = 0; push_valid = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // First push after reset is accepted normally.
    step("post_rst", 0, 0, 1, 32'h6000_0000, 32'h300);

    // Three stalled valid cycles and two flush cycles for the statistics counters.
    for (int i = 0; i < 3; i++) step("stat_stall", 0, 1, 0, '0, '0);
    for (int i = 0; i < 2; i++) step("stat_flush", 1, 0, 0, '0, '0);
`ifdef IF_ID_QUEUE_STATS_EN
    check("stats.stall_cnt", 64'(stall_cnt), 64'd3);
    check("stats.flush_cnt", 64'(flush_cnt), 64'd2);
`endif
    check("end.pc_out", 64'(pc_out), 64'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
